// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-bank write arbiter
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 8;
    localparam int AW     = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_addr_decoder.sv
// rtl/regfile_addr_decoder.sv - AW-bit register index to NREG-bit one-hot enable
//
// Ports:
//   i_addr    register index 0..NREG-1
//   o_onehot  one-hot enable, bit i_addr set
module regfile_addr_decoder
    import regfile_pkg::*;
(
    input  logic [AW-1:0]   i_addr,
    output logic [NREG-1:0] o_onehot
);

    always_comb begin
        o_onehot         = '0;
        o_onehot[i_addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin write port arbiter with clear sequencer
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   i_req0/i_addr0/i_data0  requester 0 write request (held until o_ack0)
//   o_ack0                  one-cycle pulse, requester 0 write issued this cycle
//   i_req1/i_addr1/i_data1  requester 1 write request (held until o_ack1)
//   o_ack1                  one-cycle pulse, requester 1 write issued this cycle
//   i_clr_start             pulse, starts the 8-cycle clear sequence
//   o_clr_busy              high while clear writes are issued
//   o_clr_done              one-cycle pulse on the last clear write
//   o_wr_en                 one-hot register enable to the bank (zero = no write)
//   o_wr_data               write data to the bank
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req0,
    input  logic [AW-1:0]     i_addr0,
    input  logic [DATA_W-1:0] i_data0,
    output logic              o_ack0,
    input  logic              i_req1,
    input  logic [AW-1:0]     i_addr1,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_ack1,
    input  logic              i_clr_start,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic [NREG-1:0]   o_wr_en,
    output logic [DATA_W-1:0] o_wr_data
);

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    req_id_t           r_last;
    logic [NREG-1:0]   r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_clr_busy;
    logic              r_clr_done;

    state_t            w_nxt_state;
    logic [AW-1:0]     w_nxt_cnt;
    req_id_t           w_nxt_last;
    logic [NREG-1:0]   w_nxt_wr_en;
    logic [DATA_W-1:0] w_nxt_wr_data;
    logic              w_nxt_ack0;
    logic              w_nxt_ack1;
    logic              w_nxt_clr_busy;
    logic              w_nxt_clr_done;

    // A requester whose ack is currently high is still presenting the data
    // that was just written; masking it avoids writing the same data twice.
    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;

    assign w_elig0  = i_req0 & ~r_ack0;
    assign w_elig1  = i_req1 & ~r_ack1;
    assign w_grant0 = w_elig0 & (~w_elig1 | (r_last == REQ1));
    assign w_grant1 = w_elig1 & (~w_elig0 | (r_last == REQ0));

    // Single decoder shared between the clear counter and the grant address.
    logic [AW-1:0]   w_dec_addr;
    logic [NREG-1:0] w_dec_onehot;

    assign w_dec_addr = (r_state == ST_CLEAR) ? r_cnt
                      : (w_grant1 ? i_addr1 : i_addr0);

    regfile_addr_decoder u_dec (
        .i_addr   (w_dec_addr),
        .o_onehot (w_dec_onehot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last     <= REQ1;
            r_wr_en    <= '0;
            r_wr_data  <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_last     <= w_nxt_last;
            r_wr_en    <= w_nxt_wr_en;
            r_wr_data  <= w_nxt_wr_data;
            r_ack0     <= w_nxt_ack0;
            r_ack1     <= w_nxt_ack1;
            r_clr_busy <= w_nxt_clr_busy;
            r_clr_done <= w_nxt_clr_done;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_last     = r_last;
        w_nxt_wr_en    = '0;
        w_nxt_wr_data  = r_wr_data;
        w_nxt_ack0     = 1'b0;
        w_nxt_ack1     = 1'b0;
        w_nxt_clr_busy = 1'b0;
        w_nxt_clr_done = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_clr_start) begin
                    // Clear takes precedence; pending requests wait it out.
                    w_nxt_state = ST_CLEAR;
                    w_nxt_cnt   = '0;
                end else if (w_grant0) begin
                    w_nxt_wr_en   = w_dec_onehot;
                    w_nxt_wr_data = i_data0;
                    w_nxt_ack0    = 1'b1;
                    w_nxt_last    = REQ0;
                end else if (w_grant1) begin
                    w_nxt_wr_en   = w_dec_onehot;
                    w_nxt_wr_data = i_data1;
                    w_nxt_ack1    = 1'b1;
                    w_nxt_last    = REQ1;
                end
            end

            ST_CLEAR: begin
                w_nxt_wr_en    = w_dec_onehot;
                w_nxt_wr_data  = '0;
                w_nxt_clr_busy = 1'b1;
                w_nxt_cnt      = r_cnt + 1'b1;
                if (r_cnt == AW'(NREG - 1)) begin
                    w_nxt_clr_done = 1'b1;
                    w_nxt_state    = ST_IDLE;
                end
            end

            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign o_wr_en    = r_wr_en;
    assign o_wr_data  = r_wr_data;
    assign o_ack0     = r_ack0;
    assign o_ack1     = r_ack1;
    assign o_clr_busy = r_clr_busy;
    assign o_clr_done = r_clr_done;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1;
    logic [2:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        ack0, ack1;
    logic        clr_start, clr_busy, clr_done;
    logic [7:0]  wr_en;
    logic [31:0] wr_data;

    logic [31:0] bank [8];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req0      (req0),
        .i_addr0     (addr0),
        .i_data0     (data0),
        .o_ack0      (ack0),
        .i_req1      (req1),
        .i_addr1     (addr1),
        .i_data1     (data1),
        .o_ack1      (ack1),
        .i_clr_start (clr_start),
        .o_clr_busy  (clr_busy),
        .o_clr_done  (clr_done),
        .o_wr_en     (wr_en),
        .o_wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank fed by the arbiter outputs.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) if (wr_en[i]) bank[i] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] en, input logic a0,
                           input logic a1, input logic busy, input logic done);
        chk({tag, ".wr_en"}, {24'h0, wr_en}, {24'h0, en});
        chk({tag, ".ack0"},  {31'h0, ack0},  {31'h0, a0});
        chk({tag, ".ack1"},  {31'h0, ack1},  {31'h0, a1});
        chk({tag, ".busy"},  {31'h0, clr_busy}, {31'h0, busy});
        chk({tag, ".done"},  {31'h0, clr_done}, {31'h0, done});
    endtask

    initial begin
        reset_n = 1'b0; clr_start = 1'b0;
        req0 = 1'b0; addr0 = '0; data0 = '0;
        req1 = 1'b0; addr1 = '0; data1 = '0;
        tick(); tick();
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.wr_data", wr_data, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Contention straight after reset: requester 0 wins first.
        req0 = 1'b1; addr0 = 3'd1; data0 = 32'hA0A0_0001;
        req1 = 1'b1; addr1 = 3'd6; data1 = 32'hB1B1_0006;
        tick(); chk_out("cont0", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0); chk("cont0.data", wr_data, 32'hA0A0_0001);
        tick(); chk_out("cont1", 8'h40, 1'b0, 1'b1, 1'b0, 1'b0); chk("cont1.data", wr_data, 32'hB1B1_0006);
        tick(); chk_out("cont2", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("cont3", 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        tick(); chk_out("cont_end", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bank1", bank[1], 32'hA0A0_0001);
        chk("bank6", bank[6], 32'hB1B1_0006);

        // Single write.
        req0 = 1'b1; addr0 = 3'd3; data0 = 32'hDEAD_BEEF;
        tick(); chk_out("single", 8'h08, 1'b1, 1'b0, 1'b0, 1'b0); chk("single.data", wr_data, 32'hDEAD_BEEF);
        req0 = 1'b0;
        tick(); chk_out("single_end", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single.wr_data_hold", wr_data, 32'hDEAD_BEEF);
        chk("bank3", bank[3], 32'hDEAD_BEEF);

        // Load every register with a nonzero value.
        for (int i = 0; i < 8; i++) begin
            req1 = 1'b1; addr1 = 3'(i); data1 = 32'h100 + 32'(i);
            tick(); chk_out("load", 8'(1 << i), 1'b0, 1'b1, 1'b0, 1'b0);
            req1 = 1'b0;
            tick();
        end
        for (int i = 0; i < 8; i++) chk("load.bank", bank[i], 32'h100 + 32'(i));

        // Clear with req1 pending; a second clr_start mid-sequence is ignored.
        clr_start = 1'b1;
        tick(); chk_out("clr_start", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_start = 1'b0;
        req1 = 1'b1; addr1 = 3'd5; data1 = 32'h55;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("clr", 8'(1 << i), 1'b0, 1'b0, 1'b1, (i == 7));
            chk("clr.data", wr_data, 32'h0);
            clr_start = (i == 2);
        end
        clr_start = 1'b0;
        tick(); chk_out("clr_after", 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("clr_after.data", wr_data, 32'h55);
        for (int i = 0; i < 8; i++) chk("clr.bank", bank[i], 32'h0);
        req1 = 1'b0;
        tick(); chk_out("clr_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr.bank5", bank[5], 32'h55);

        // clr_start and req0 at the same edge: clear first, then the write.
        clr_start = 1'b1; req0 = 1'b1; addr0 = 3'd2; data0 = 32'h5;
        tick(); chk_out("sim_start", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("sim_clr", 8'(1 << i), 1'b0, 1'b0, 1'b1, (i == 7));
        end
        tick(); chk_out("sim_wr", 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sim_wr.data", wr_data, 32'h5);
        req0 = 1'b0;
        tick();
        chk("sim.bank2", bank[2], 32'h5);
        chk("sim.bank5", bank[5], 32'h0);

        // Reset after the third clear write.
        clr_start = 1'b1;
        tick(); clr_start = 1'b0;
        tick(); tick(); tick();
        chk_out("mid_clr", 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst.data", wr_data, 32'h0);
        tick();
        reset_n = 1'b1;
        tick(); chk_out("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_start = 1'b1;
        tick(); clr_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("restart", 8'(1 << i), 1'b0, 1'b0, 1'b1, (i == 7));
        end
        tick(); chk_out("restart_end", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
